// File: rtl/bellek_yanitlayici_pkg.sv
// Shared memory-port definitions: base address, bus widths and responder state encoding.
package bellek_yanitlayici_pkg;

  localparam logic [31:0] BELLEK_ADRES = 32'h8000_0000;
  localparam int unsigned VERI_BIT     = 32;
  localparam int unsigned ADRES_BIT    = 32;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } bellek_durum_t;

endpackage

// File: rtl/bellek_yanitlayici_dizisi.sv
// bellek_dizisi: synchronous single-port word array, 4-bit byte write enable, registered read.
module bellek_dizisi #(
  parameter int unsigned DERINLIK = 1024,
  parameter int unsigned VERI_BIT = bellek_yanitlayici_pkg::VERI_BIT,
  localparam int unsigned AW      = $clog2(DERINLIK)
) (
  input  logic                clk,
  input  logic                en,
  input  logic [3:0]          yaz_en,
  input  logic [AW-1:0]       adres,
  input  logic [VERI_BIT-1:0] yaz_veri,
  output logic [VERI_BIT-1:0] oku_veri
);
  import bellek_yanitlayici_pkg::*;

  logic [VERI_BIT-1:0] dizi [DERINLIK];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (yaz_en[i]) dizi[adres][8*i +: 8] <= yaz_veri[8*i +: 8];
      end
      oku_veri <= dizi[adres];
    end
  end

endmodule

// File: rtl/bellek_yanitlayici.sv
// Memory responder with programmable wait states and range error reporting.
// Optional misaligned-address error: define ADRES_HIZALAMA_DENETIM_EN.
module bellek_yanitlayici #(
  parameter int unsigned VERI_BIT                 = bellek_yanitlayici_pkg::VERI_BIT,
  parameter int unsigned ADRES_BIT                = bellek_yanitlayici_pkg::ADRES_BIT,
  parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRES = bellek_yanitlayici_pkg::BELLEK_ADRES,
  parameter int unsigned DERINLIK                 = 1024,
  parameter int unsigned GECIKME                  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bellek_istek,
  input  logic [ADRES_BIT-1:0] bellek_adres,
  input  logic                 bellek_yaz,
  input  logic [VERI_BIT-1:0]  bellek_yaz_veri,
  input  logic [3:0]           bellek_maske,
  output logic [VERI_BIT-1:0]  bellek_oku_veri,
  output logic                 bellek_hazir,
  output logic                 bellek_hata
);
  import bellek_yanitlayici_pkg::*;

  localparam int unsigned    AW        = $clog2(DERINLIK);
  localparam logic [ADRES_BIT:0] ALT   = {1'b0, BASLANGIC_ADRES};
  localparam logic [ADRES_BIT:0] UST   = ALT + (ADRES_BIT+1)'(4 * DERINLIK);
  localparam logic [3:0]     SAYAC_BAS = (GECIKME > 0) ? 4'(GECIKME - 1) : 4'd0;

  bellek_durum_t durum, durum_sonraki;
  logic [3:0] sayac, sayac_sonraki;
  logic       giris;

  logic [ADRES_BIT-1:0] l_adres;
  logic                 l_yaz;
  logic [VERI_BIT-1:0]  l_veri;
  logic [3:0]           l_maske;

  logic [ADRES_BIT-1:0] e_adres;
  logic                 e_yaz;
  logic [VERI_BIT-1:0]  e_veri;
  logic [3:0]           e_maske;

  logic                 aralikta, hizali, gecerli;
  logic [AW-1:0]        indeks;
  logic                 dizi_en;
  logic [3:0]           dizi_yaz_en;
  logic [VERI_BIT-1:0]  dizi_veri;
  logic                 oku_gecerli;

  // With zero latency the accept edge is also the YANIT entry edge, so the live inputs are used.
  always_comb begin
    e_adres = l_adres;
    e_yaz   = l_yaz;
    e_veri  = l_veri;
    e_maske = l_maske;
    if (durum == BOS) begin
      e_adres = bellek_adres;
      e_yaz   = bellek_yaz;
      e_veri  = bellek_yaz_veri;
      e_maske = bellek_maske;
    end
  end

  assign aralikta = ({1'b0, e_adres} >= ALT) && ({1'b0, e_adres} < UST);
`ifdef ADRES_HIZALAMA_DENETIM_EN
  assign hizali = (e_adres[1:0] == 2'b00);
`else
  assign hizali = 1'b1;
`endif
  assign gecerli = aralikta && hizali;
  assign indeks  = AW'((e_adres - BASLANGIC_ADRES) >> 2);

  always_comb begin
    durum_sonraki = durum;
    sayac_sonraki = sayac;
    giris         = 1'b0;
    unique case (durum)
      BOS: begin
        if (bellek_istek) begin
          if (GECIKME == 0) begin
            durum_sonraki = YANIT;
            giris         = 1'b1;
          end else begin
            durum_sonraki = BEKLE;
            sayac_sonraki = SAYAC_BAS;
          end
        end
      end
      BEKLE: begin
        if (sayac == 4'd0) begin
          durum_sonraki = YANIT;
          giris         = 1'b1;
        end else begin
          sayac_sonraki = sayac - 4'd1;
        end
      end
      YANIT:   durum_sonraki = BOS;
      default: durum_sonraki = BOS;
    endcase
  end

  // Gated by rst so a request presented while reset is held can never commit.
  assign dizi_en     = giris && gecerli && !rst;
  assign dizi_yaz_en = (dizi_en && e_yaz) ? e_maske : 4'b0000;

  bellek_dizisi #(
    .DERINLIK(DERINLIK),
    .VERI_BIT(VERI_BIT)
  ) u_dizi (
    .clk      (clk),
    .en       (dizi_en),
    .yaz_en   (dizi_yaz_en),
    .adres    (indeks),
    .yaz_veri (e_veri),
    .oku_veri (dizi_veri)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum        <= BOS;
      sayac        <= '0;
      l_adres      <= '0;
      l_yaz        <= 1'b0;
      l_veri       <= '0;
      l_maske      <= '0;
      bellek_hazir <= 1'b0;
      bellek_hata  <= 1'b0;
      oku_gecerli  <= 1'b0;
    end else begin
      durum <= durum_sonraki;
      sayac <= sayac_sonraki;
      if (durum == BOS && bellek_istek) begin
        l_adres <= bellek_adres;
        l_yaz   <= bellek_yaz;
        l_veri  <= bellek_yaz_veri;
        l_maske <= bellek_maske;
      end
      bellek_hazir <= giris;
      bellek_hata  <= giris && !gecerli;
      oku_gecerli  <= giris && gecerli && !e_yaz;
    end
  end

  // Array read register is not reset; the qualifier flop keeps the output at zero otherwise.
  assign bellek_oku_veri = oku_gecerli ? dizi_veri : '0;

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Scoreboard bench: one responder with two wait states, one with zero latency.
module tb_bellek_yanitlayici;

  localparam int unsigned GECIKME0 = 2;
  localparam int unsigned GECIKME1 = 0;

  typedef struct {
    logic [31:0] veri;
    logic        hata;
    int unsigned cyc;
  } beklenen_t;

  typedef struct {
    logic [31:0] adres;
    logic        yaz;
    logic [31:0] veri;
    logic [3:0]  maske;
    logic [31:0] b_veri;
    logic        b_hata;
  } istek_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        istek0 = 1'b0, yaz0 = 1'b0;
  logic [31:0] adres0 = '0, veri0 = '0;
  logic [3:0]  maske0 = '0;
  logic [31:0] oku0;
  logic        hazir0, hata0;

  logic        istek1 = 1'b0, yaz1 = 1'b0;
  logic [31:0] adres1 = '0, veri1 = '0;
  logic [3:0]  maske1 = '0;
  logic [31:0] oku1;
  logic        hazir1, hata1;

  int unsigned cyc = 0;
  int unsigned compared = 0;
  int unsigned errors = 0;

  beklenen_t q0[$];
  beklenen_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bellek_yanitlayici #(.DERINLIK(1024), .GECIKME(GECIKME0)) dut0 (
    .clk(clk), .rst(rst), .bellek_istek(istek0), .bellek_adres(adres0),
    .bellek_yaz(yaz0), .bellek_yaz_veri(veri0), .bellek_maske(maske0),
    .bellek_oku_veri(oku0), .bellek_hazir(hazir0), .bellek_hata(hata0)
  );

  bellek_yanitlayici #(.DERINLIK(1024), .GECIKME(GECIKME1)) dut1 (
    .clk(clk), .rst(rst), .bellek_istek(istek1), .bellek_adres(adres1),
    .bellek_yaz(yaz1), .bellek_yaz_veri(veri1), .bellek_maske(maske1),
    .bellek_oku_veri(oku1), .bellek_hazir(hazir1), .bellek_hata(hata1)
  );

  function automatic void karsilastir(string ad, logic [31:0] gercek, logic [31:0] beklenen);
    compared++;
    if (gercek !== beklenen) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", ad, gercek, beklenen, cyc);
    end
  endfunction

  always @(negedge clk) begin
    beklenen_t b;
    if (!rst && hazir0) begin
      if (q0.size() == 0) karsilastir("beklenmeyen_hazir0", 32'd1, 32'd0);
      else begin
        b = q0.pop_front();
        karsilastir("oku_veri0", oku0, b.veri);
        karsilastir("hata0", {31'd0, hata0}, {31'd0, b.hata});
        karsilastir("gecikme0", cyc, b.cyc);
      end
    end
    if (!rst && hazir1) begin
      if (q1.size() == 0) karsilastir("beklenmeyen_hazir1", 32'd1, 32'd0);
      else begin
        b = q1.pop_front();
        karsilastir("oku_veri1", oku1, b.veri);
        karsilastir("hata1", {31'd0, hata1}, {31'd0, b.hata});
        karsilastir("gecikme1", cyc, b.cyc);
      end
    end
  end

  task automatic gonder(input logic [31:0] a, input logic y, input logic [31:0] v,
                        input logic [3:0] m, input logic [31:0] b_veri, input logic b_hata);
    bit bitti = 0;
    @(negedge clk);
    adres0 = a; yaz0 = y; veri0 = v; maske0 = m; istek0 = 1'b1;
    q0.push_back('{b_veri, b_hata, cyc + GECIKME0 + 1});
    @(posedge clk);
    #1;
    // scramble inputs after accept; the latched copy must be used
    adres0 = ~a; yaz0 = ~y; veri0 = ~v; maske0 = ~m;
    for (int i = 0; i < 20 && !bitti; i++) begin
      @(negedge clk);
      if (hazir0) bitti = 1;
    end
    if (!bitti) karsilastir("zaman_asimi0", 32'd0, 32'd1);
    istek0 = 1'b0;
  endtask

  initial begin
    istek_t dizi1[5];
    bit bitti;

    #1;
    @(negedge clk);
    karsilastir("reset_hazir", {31'd0, hazir0}, 32'd0);
    karsilastir("reset_hata", {31'd0, hata0}, 32'd0);
    karsilastir("reset_oku_veri", oku0, 32'd0);
    karsilastir("reset_hazir1", {31'd0, hazir1}, 32'd0);
    rst = 1'b0;

    gonder(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    gonder(32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
    gonder(32'h8000_0010, 1'b1, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0);
    gonder(32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0);
    gonder(32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    gonder(32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0);
    gonder(32'h8000_1000, 1'b0, 32'h0,         4'h0, 32'h0, 1'b1);
    gonder(32'h7FFF_FFFC, 1'b0, 32'h0,         4'h0, 32'h0, 1'b1);
    gonder(32'h8000_0000, 1'b1, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0);
    gonder(32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
    gonder(32'h8000_0000, 1'b0, 32'h0,         4'h0, 32'h0BAD_CAFE, 1'b0);
    gonder(32'h8000_0FFC, 1'b1, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0);
    gonder(32'h8000_0FFC, 1'b0, 32'h0,         4'h0, 32'hA5A5_5A5A, 1'b0);
    gonder(32'h8000_0020, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);

    // write aborted by reset while waiting
    @(negedge clk);
    adres0 = 32'h8000_0020; yaz0 = 1'b1; veri0 = 32'h1234_5678; maske0 = 4'hF; istek0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; istek0 = 1'b0;
    #1;
    karsilastir("abort_hazir", {31'd0, hazir0}, 32'd0);
    karsilastir("abort_hata", {31'd0, hata0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      karsilastir("abort_sonrasi_hazir", {31'd0, hazir0}, 32'd0);
    end
    gonder(32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

`ifdef ADRES_HIZALAMA_DENETIM_EN
    gonder(32'h8000_0012, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
`else
    gonder(32'h8000_0012, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0);
`endif

    // zero-latency responder, request held high throughout
    dizi1[0] = '{32'h8000_0040, 1'b1, 32'h1111_1111, 4'hF, 32'h0, 1'b0};
    dizi1[1] = '{32'h8000_0044, 1'b1, 32'h2222_2222, 4'hF, 32'h0, 1'b0};
    dizi1[2] = '{32'h8000_0040, 1'b0, 32'h0, 4'h0, 32'h1111_1111, 1'b0};
    dizi1[3] = '{32'h8000_0044, 1'b0, 32'h0, 4'h0, 32'h2222_2222, 1'b0};
    dizi1[4] = '{32'h8000_1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1};
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      adres1 = dizi1[k].adres; yaz1 = dizi1[k].yaz; veri1 = dizi1[k].veri; maske1 = dizi1[k].maske;
      istek1 = 1'b1;
      q1.push_back('{dizi1[k].b_veri, dizi1[k].b_hata, (k == 0) ? cyc + 1 : cyc + 2});
      bitti = 0;
      for (int i = 0; i < 20 && !bitti; i++) begin
        @(negedge clk);
        if (hazir1) bitti = 1;
      end
      if (!bitti) karsilastir("zaman_asimi1", 32'd0, 32'd1);
    end
    istek1 = 1'b0;

    repeat (5) @(negedge clk);
    karsilastir("kuyruk0_bos", 32'(q0.size()), 32'd0);
    karsilastir("kuyruk1_bos", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
